signed_window_ffe: RTL
======================

Name: signed_window_ffe

Overview:
- Feed-forward equalizer stage directly downstream of the flat signed history buffer.
- Consumes the buffer's per-channel history array (numChannels x depth+1 signed samples) and computes one FIR output per channel per clock.
- Tap weights are shared by all channels and are written through a shadow/commit register interface.
- Two-cycle pipelined datapath (multiply, then sum/shift/saturate) with a valid flag carried alongside.

Parameters:
- numChannels, 16, parallel lanes per clock
- bitwidth, 8, input sample width (signed)
- depth, 5, history depth of the upstream buffer (columns 0..depth)
- numTaps, 4, FIR taps; legal range 1 .. depth*numChannels+1
- weightBitwidth, 10, signed tap weight width
- outBitwidth, 10, signed output width after shift and saturate
- shiftBits, 4, arithmetic right shift applied to the full-precision sum

Ports:
- clk  in  1  clock
- rstb  in  1  asynchronous active-low reset
- in_buf  in  signed [bitwidth-1:0] x [numChannels][depth+1]  upstream history; column 0 is newest
- in_valid  in  1  in_buf holds a valid window this cycle
- wt_wr_en  in  1  write wt_wr_data into shadow[wt_wr_addr]
- wt_wr_addr  in  $clog2(numTaps)  shadow weight index
- wt_wr_data  in  signed [weightBitwidth-1:0]  weight value
- wt_commit  in  1  copy all shadow weights to active weights
- out  out  signed [outBitwidth-1:0] x [numChannels]  equalized samples
- out_valid  out  1  out is valid
- sat_flag  out  1  sticky flag: at least one lane saturated since reset

Behaviour:
- Reset (rstb low, asynchronous): shadow and active weights = 0, pipeline registers = 0, out = 0, out_valid = 0, sat_flag = 0.
- Flat index: flat[(depth-d)*numChannels + ch] = in_buf[ch][d]. The highest index is the newest sample.
- Lane ch, tap k: sample = flat[depth*numChannels + ch - k]. Tap 0 is the current sample of the lane.
- Cycle N+1 (stage 1): register prod[ch][k] = sample*active_w[k], full width bitwidth+weightBitwidth. Register v1 = in_valid.
- Cycle N+2 (stage 2): sum all taps at width bitwidth+weightBitwidth+$clog2(numTaps), arithmetic shift right by shiftBits (floor), saturate to [-2^(outBitwidth-1), 2^(outBitwidth-1)-1]. Register the result to out and register out_valid = v1.
- Total latency: 2 clocks from in_valid/in_buf to out_valid/out.
- Stage registers load every cycle regardless of in_valid. out holds whatever was computed, and consumers must qualify it with out_valid.
- sat_flag is set when any lane saturates in a cycle where v1=1. It clears only on reset.
- Weight writes: a write to shadow takes effect on the next clock and has no effect on the datapath until commit.
  - wt_wr_addr >= numTaps: the write is ignored.
- Commit: active weights take the shadow values on the next clock edge. Data entering stage 1 on that same edge still uses the old weights, so the weight change is atomic per window.
- wt_wr_en and wt_commit asserted in the same cycle: commit copies the pre-write shadow, and the new write lands in shadow only. The active weights therefore do not include that write.
- Reset asserted mid-stream: everything clears immediately, and out_valid drops asynchronously.
  - After release, the first out_valid appears 2 clocks after the first in_valid.

Decomposition:
- Package ffe_pkg holds:
  - localparam function for sum width
  - saturate function (parameterized by widths via the caller)
  - typedef for the weight array
- Sub-module ffe_lane: one channel's multiply/sum/shift/saturate pipeline, with the tap samples and active weights as inputs.
  - Top instantiates numChannels lanes and owns the shadow/active weight registers, the valid pipe and sat_flag.

Test Plan:
- Reset then identity: write w[0]=16 (others 0), commit, shiftBits=4, in_buf[ch][0]=ch-8 with in_valid=1 -> 2 clocks later out[ch]=ch-8, out_valid=1, sat_flag=0.
- Cross-channel tap: w[1]=16 only, in_buf[ch][0]=ch, in_buf[ch][1]=100+ch -> out[ch]=ch-1 for ch>=1, and out[0]=115 (the previous column's lane 15).
- Saturation: w[0]=511, in_buf[0][0]=127 (all others 0) -> sum 64897, >>4 = 4056 -> out[0]=511 and sat_flag=1. With in_buf=-128 and w[0]=511 -> out[0]=-512.
- Shadow isolation: write w[0]=32 without commit -> outputs unchanged. Commit -> windows entering after the commit edge use 32. Write and commit in the same cycle -> the active weight is the prior shadow value.
- Valid pipe: in_valid pattern 1,0,1,1 -> out_valid 0,0,1,0,1,1. An out-of-range wt_wr_addr leaves the weights unchanged.
- Reset mid-stream: drop rstb while out_valid=1 -> out=0 and out_valid=0 immediately, weights=0. Release and re-drive -> valid output 2 clocks after the first in_valid.

Source files
------------

// File: rtl/ffe_pkg.sv
// Shared helpers for the signed window feed-forward equalizer: accumulator sizing,
// output saturation and the default weight-array shape.
package ffe_pkg;

    localparam int DEFAULT_NUM_TAPS        = 4;
    localparam int DEFAULT_WEIGHT_BITWIDTH = 10;

    typedef logic signed [DEFAULT_WEIGHT_BITWIDTH-1:0] weight_arr_t [DEFAULT_NUM_TAPS];

    // Width that holds the sum of numTaps full-precision products without overflow.
    function automatic int sum_width(input int bw, input int wbw, input int taps);
        return bw + wbw + $clog2(taps);
    endfunction

    function automatic logic signed [63:0] saturate(input logic signed [63:0] val,
                                                    input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (val > hi) return hi;
        if (val < lo) return lo;
        return val;
    endfunction

endpackage

// File: rtl/ffe_lane.sv
// One equalizer lane: registered tap products, then sum, floor shift and saturate
// into the registered output.
module ffe_lane
    import ffe_pkg::*;
#(
    parameter int bitwidth       = 8,
    parameter int weightBitwidth = 10,
    parameter int numTaps        = 4,
    parameter int outBitwidth    = 10,
    parameter int shiftBits      = 4
) (
    input  logic                             clk,
    input  logic                             rstb,
    input  logic signed [bitwidth-1:0]       samples [numTaps],
    input  logic signed [weightBitwidth-1:0] weights [numTaps],
    output logic signed [outBitwidth-1:0]    out,
    output logic                             sat
);

    localparam int PROD_W = bitwidth + weightBitwidth;
    localparam int SUM_W  = sum_width(bitwidth, weightBitwidth, numTaps);

    logic signed [PROD_W-1:0] prod [numTaps];
    logic signed [SUM_W-1:0]  sum;
    logic signed [SUM_W-1:0]  shifted;
    logic signed [63:0]       wide;
    logic signed [63:0]       clipped;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int k = 0; k < numTaps; k++) prod[k] <= '0;
        end else begin
            for (int k = 0; k < numTaps; k++)
                prod[k] <= PROD_W'(samples[k]) * PROD_W'(weights[k]);
        end
    end

    // sat reports the lane clipped this cycle; the top qualifies it with the valid pipe.
    always_comb begin
        sum = '0;
        for (int k = 0; k < numTaps; k++) sum = sum + SUM_W'(prod[k]);
        shifted = sum >>> shiftBits;
        wide    = 64'(shifted);
        clipped = saturate(wide, outBitwidth);
    end

    assign sat = (clipped != wide);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) out <= '0;
        else       out <= clipped[outBitwidth-1:0];
    end

endmodule

// File: rtl/signed_window_ffe.sv
// Multi-lane FIR equalizer over the flat signed history window, with shared
// shadow/commit tap weights, a two-stage valid pipe and a sticky saturation flag.
module signed_window_ffe
    import ffe_pkg::*;
#(
    parameter int numChannels    = 16,
    parameter int bitwidth       = 8,
    parameter int depth          = 5,
    parameter int numTaps        = DEFAULT_NUM_TAPS,
    parameter int weightBitwidth = DEFAULT_WEIGHT_BITWIDTH,
    parameter int outBitwidth    = 10,
    parameter int shiftBits      = 4
) (
    input  logic                                             clk,
    input  logic                                             rstb,
    input  logic signed [bitwidth-1:0]                       in_buf [numChannels][depth+1],
    input  logic                                             in_valid,
    input  logic                                             wt_wr_en,
    input  logic [((numTaps > 1) ? $clog2(numTaps) : 1)-1:0] wt_wr_addr,
    input  logic signed [weightBitwidth-1:0]                 wt_wr_data,
    input  logic                                             wt_commit,
    output logic signed [outBitwidth-1:0]                    out [numChannels],
    output logic                                             out_valid,
    output logic                                             sat_flag
);

    logic signed [weightBitwidth-1:0] shadow_w [numTaps];
    logic signed [weightBitwidth-1:0] active_w [numTaps];
    logic signed [bitwidth-1:0]       taps [numChannels][numTaps];
    logic [numChannels-1:0]           lane_sat;
    logic                             v1;

    // Commit reads shadow before this edge's write lands, so a same-cycle write
    // stays in shadow only.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int k = 0; k < numTaps; k++) begin
                shadow_w[k] <= '0;
                active_w[k] <= '0;
            end
        end else begin
            if (wt_commit) active_w <= shadow_w;
            if (wt_wr_en && (int'(wt_wr_addr) < numTaps))
                shadow_w[wt_wr_addr] <= wt_wr_data;
        end
    end

    // Tap k of lane ch is flat index depth*numChannels+ch-k, where
    // flat[(depth-d)*numChannels+c] = in_buf[c][d]; older taps spill into earlier lanes.
    for (genvar ch = 0; ch < numChannels; ch++) begin : g_lane
        for (genvar k = 0; k < numTaps; k++) begin : g_tap
            localparam int FLAT = depth * numChannels + ch - k;
            assign taps[ch][k] = in_buf[FLAT % numChannels][depth - FLAT / numChannels];
        end

        ffe_lane #(
            .bitwidth      (bitwidth),
            .weightBitwidth(weightBitwidth),
            .numTaps       (numTaps),
            .outBitwidth   (outBitwidth),
            .shiftBits     (shiftBits)
        ) u_lane (
            .clk    (clk),
            .rstb   (rstb),
            .samples(taps[ch]),
            .weights(active_w),
            .out    (out[ch]),
            .sat    (lane_sat[ch])
        );
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            v1        <= 1'b0;
            out_valid <= 1'b0;
            sat_flag  <= 1'b0;
        end else begin
            v1        <= in_valid;
            out_valid <= v1;
            if (v1 && (|lane_sat)) sat_flag <= 1'b1;
        end
    end

endmodule
